multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle RISC-V datapath: one memory port, one ALU, instruction register (IR), and PC update through the ALU.
- Supports R-type (0110011), lw (0000011), sw (0100011) and beq (1100011).
- Uses the same 2-bit ALUOp encoding the ALU decoder already consumes: 00 add, 01 subtract/compare, 10 funct-decoded.
- Adds a memory-ready handshake, a retired-instruction counter and an illegal-opcode halt.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op  input  7  opcode from IR[6:0]; stable from DECODE until instruction completes.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC load enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  IR (and OldPC) load enable.
- MemWrite  output  1  memory write request.
- RegWrite  output  1  register-file write enable.
- ResultSrc  output  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  output  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4.
- ALUOp  output  2  ALU decoder class.
- illegal  output  1  sticky illegal-opcode flag.
- state  output  4  current state encoding, for debug.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, BEQ=8, HALT=9.
- Per-state outputs; any output not listed is 0.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready and PCUpdate=mem_ready. Next state is DECODE if mem_ready, otherwise stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch target). Next state by op:
    - lw or sw -> MEMADR
    - 0110011 -> EXECUTER
    - 1100011 -> BEQ
    - any other op -> HALT
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Stays until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready. Next state FETCH on mem_ready.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH.
  - HALT: all enables 0, illegal=1. Leaves HALT only on reset.
- PCWrite = PCUpdate | (Branch & Zero), combinational.
- Cycle counts per instruction with mem_ready tied to 1: lw 5, sw 4, R-type 4, beq 3. Each low cycle of mem_ready adds one cycle in FETCH, MEMREAD or MEMWRITE.
- instret:
  - Increments by 1 on the clock edge leaving MEMWB, ALUWB or BEQ, and on the edge leaving MEMWRITE with mem_ready=1.
  - Wraps modulo 2^CNT_W silently.
  - Does not increment on entering HALT.
- Reset: rst_n low immediately (asynchronously) forces:
  - state=FETCH, instret=0, illegal=0;
  - PCWrite, IRWrite, MemWrite, RegWrite = 0 while rst_n is low, regardless of mem_ready;
  - select outputs take their FETCH values.
- Reset asserted mid-instruction (e.g. in MEMWRITE) drops MEMWRITE the same instant; no partial retire is counted.
- First rising edge after rst_n deassertion evaluates FETCH normally.
- op is sampled only in DECODE and MEMADR; changes of op in other states have no effect.

Test Plan:
- Reset then lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 with ResultSrc=01 only in state 4; instret=1.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for exactly 4 cycles, AdrSrc=1; instret increments on the 4th edge only.
- beq with Zero=1 -> PCWrite=1 in BEQ with ALUOp=01. Repeat with Zero=0 -> PCWrite=0 in BEQ. Both take 3 cycles.
- R-type back-to-back ×3 -> ALUOp=10 in EXECUTER; 12 cycles total; instret=3.
- op=0000000 at DECODE -> state=9, illegal=1, all enables 0 for ≥10 cycles; rst_n pulse -> state=0, illegal=0.
- FETCH with mem_ready=0 for 5 cycles -> IRWrite=PCWrite=0, state stays 0. instret preloaded near 2^CNT_W-1 (force CNT_W=4, 16 R-types) -> wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-memory multicycle RISC-V datapath (R-type, lw, sw, beq),
// with a memory-ready handshake, a retired-instruction counter and a sticky illegal-opcode halt.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             retire;
  logic             pc_update;
  logic             branch;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                  ((state_q == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_d == S_HALT) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
    // Reset forces FETCH asynchronously; the mem_ready-driven enables must still stay low.
    if (!rst_n) begin
      pc_update = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
    end
  end

  assign PCWrite = pc_update | (branch & Zero);
  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level script predicts every cycle's
// state/outputs/counter; a negedge monitor pops and compares. A CNT_W=4 copy checks wrap.
module tb_multicycle_control;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, ALUWB = 4'd7,
                         BEQ = 4'd8, HALT = 4'd9;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        s_PCWrite, s_AdrSrc, s_IRWrite, s_MemWrite, s_RegWrite, s_illegal;
  logic [1:0]  s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ALUOp;
  logic [3:0]  s_state;
  logic [3:0]  s_instret;

  multicycle_control u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegal(illegal), .state(state), .instret(instret)
  );

  multicycle_control #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(s_PCWrite), .AdrSrc(s_AdrSrc), .IRWrite(s_IRWrite), .MemWrite(s_MemWrite),
    .RegWrite(s_RegWrite), .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
    .ALUOp(s_ALUOp), .illegal(s_illegal), .state(s_state), .instret(s_instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] sig;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          failures = 0;
  logic [31:0] cnt_m = '0;
  logic        ill_m = 1'b0;

  // Expected outputs for a state, straight from the per-state output table.
  function automatic logic [17:0] exp_sig(input logic [3:0] st, input logic mr, input logic z,
                                          input logic rstn, input logic ill);
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] rs, asa, asb, aop;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0;
    rs = 2'b00; asa = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      FETCH:    begin asb = 2'b10; rs = 2'b10; irw = mr & rstn; pcw = mr & rstn; end
      DECODE:   begin asa = 2'b01; asb = 2'b01; end
      MEMADR:   begin asa = 2'b10; asb = 2'b01; end
      MEMREAD:  adr = 1'b1;
      MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      EXECUTER: begin asa = 2'b10; aop = 2'b10; end
      ALUWB:    rw = 1'b1;
      BEQ:      begin asa = 2'b10; aop = 2'b01; pcw = z; end
      default:  ;
    endcase
    return {st, ill, pcw, adr, irw, mw, rw, rs, asa, asb, aop};
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  task automatic step(input logic [3:0] st, input logic rstn, input logic mr,
                      input logic z, input logic [6:0] opv);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn; mem_ready = mr; Zero = z; op = opv;
    if (!rstn) begin cnt_m = '0; ill_m = 1'b0; end
    e.sig  = exp_sig(st, mr, z, rstn, ill_m);
    e.cnt  = cnt_m;
    e.cnt4 = cnt_m[3:0];
    exp_q.push_back(e);
  endtask

  // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 illegal opcode (then halt_cyc cycles in HALT)
  task automatic run_instr(input int kind, input int fw, input int mw, input logic z,
                           input int halt_cyc);
    logic [6:0] opv;
    case (kind)
      0: opv = OP_LW;
      1: opv = OP_SW;
      2: opv = OP_R;
      3: opv = OP_BEQ;
      default: begin
        opv = junk();
        while (opv == OP_LW || opv == OP_SW || opv == OP_R || opv == OP_BEQ) opv = junk();
      end
    endcase
    for (int i = 0; i < fw; i++) step(FETCH, 1'b1, 1'b0, 1'($urandom), junk());
    step(FETCH, 1'b1, 1'b1, 1'($urandom), junk());
    step(DECODE, 1'b1, 1'($urandom), 1'($urandom), opv);
    case (kind)
      0: begin
        step(MEMADR, 1'b1, 1'($urandom), 1'($urandom), opv);
        for (int i = 0; i < mw; i++) step(MEMREAD, 1'b1, 1'b0, 1'($urandom), junk());
        step(MEMREAD, 1'b1, 1'b1, 1'($urandom), junk());
        step(MEMWB, 1'b1, 1'($urandom), 1'($urandom), junk());
        cnt_m = cnt_m + 1;
      end
      1: begin
        step(MEMADR, 1'b1, 1'($urandom), 1'($urandom), opv);
        for (int i = 0; i < mw; i++) step(MEMWRITE, 1'b1, 1'b0, 1'($urandom), junk());
        step(MEMWRITE, 1'b1, 1'b1, 1'($urandom), junk());
        cnt_m = cnt_m + 1;
      end
      2: begin
        step(EXECUTER, 1'b1, 1'($urandom), 1'($urandom), junk());
        step(ALUWB, 1'b1, 1'($urandom), 1'($urandom), junk());
        cnt_m = cnt_m + 1;
      end
      3: begin
        step(BEQ, 1'b1, 1'($urandom), z, junk());
        cnt_m = cnt_m + 1;
      end
      default: begin
        ill_m = 1'b1;
        for (int i = 0; i < halt_cyc; i++)
          step(HALT, 1'b1, 1'($urandom), 1'($urandom), junk());
      end
    endcase
  endtask

  initial begin : monitor
    exp_t e;
    logic [17:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {state, illegal, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
        tests++;
        if (got !== e.sig) begin
          failures++;
          $display("FAIL ctrl_outputs t=%0t: got state=%0d sig=%h required state=%0d sig=%h",
                   $time, got[17:14], got, e.sig[17:14], e.sig);
        end
        tests++;
        if (instret !== e.cnt) begin
          failures++;
          $display("FAIL instret t=%0t: got %0d required %0d", $time, instret, e.cnt);
        end
        tests++;
        if (s_instret !== e.cnt4) begin
          failures++;
          $display("FAIL instret_w4 t=%0t: got %0d required %0d", $time, s_instret, e.cnt4);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cyc;
    step(FETCH, 1'b0, 1'b1, 1'b0, junk());
    step(FETCH, 1'b0, 1'b1, 1'b1, junk());
    run_instr(0, 0, 0, 1'b0, 0);
    run_instr(1, 0, 3, 1'b0, 0);
    run_instr(3, 0, 0, 1'b1, 0);
    run_instr(3, 0, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) run_instr(2, 0, 0, 1'b0, 0);
    run_instr(4, 0, 0, 1'b0, 12);
    step(FETCH, 1'b0, 1'b1, 1'b0, junk());
    run_instr(2, 5, 0, 1'b0, 0);
    // Reset dropped in the middle of a stalled store
    step(FETCH, 1'b1, 1'b1, 1'b0, junk());
    step(DECODE, 1'b1, 1'b0, 1'b0, OP_SW);
    step(MEMADR, 1'b1, 1'b0, 1'b0, OP_SW);
    step(MEMWRITE, 1'b1, 1'b0, 1'b0, junk());
    step(FETCH, 1'b0, 1'b1, 1'b0, junk());
    for (int i = 0; i < 17; i++) run_instr(2, 0, 0, 1'b0, 0);
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom), 0);
    run_instr(4, 1, 0, 1'b0, 10);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
